cmd_encode: RTL and testbench
=============================

CMD_ENCODE -- requirements
Module: cmd_encode

Interface
REQ-001 Parameter HDR_WR, default 8'h55, header byte of a write-command frame.
REQ-002 Parameter HDR_RD, default 8'hAA, header byte of a read-command frame.
REQ-003 Parameter DATA_BYTES, default 4, payload bytes per write frame, legal range 1..8.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 cmd_valid  input  1  command request present.
REQ-007 cmd_ready  output  1  encoder accepts command this cycle.
REQ-008 cmd_rd  input  1  1 = read command, 0 = write command; sampled at accept.
REQ-009 cmd_data  input  8*DATA_BYTES  write payload; sampled at accept, ignored for reads.
REQ-010 tx_data  output  8  current frame byte.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  downstream byte sink (UART transmitter) takes byte.
REQ-013 busy  output  1  frame in progress.
REQ-014 frame_done  output  1  one-cycle pulse after last byte of a frame transfers.

Function
REQ-015 The encoder SHALL generate the command frames consumed by the UART command decoder: write = HDR_WR then DATA_BYTES payload bytes; read = HDR_RD only.
REQ-016 Payload SHALL be sent most-significant byte first (cmd_data[8*DATA_BYTES-1 -: 8] first).
REQ-017 Command accept SHALL occur on a cycle with cmd_valid && cmd_ready; cmd_ready = 1 only in IDLE.
REQ-018 On accept, cmd_rd and cmd_data SHALL be registered; later changes to inputs SHALL not affect the frame.
REQ-019 FSM states: IDLE, HDR, DATA, DONE.
REQ-020 IDLE -> HDR on accept; HDR -> DATA on header transfer for write; HDR -> DONE on header transfer for read; DATA -> DONE on last payload transfer; DONE -> IDLE unconditionally after one cycle.
REQ-021 A byte transfer SHALL occur only on tx_valid && tx_ready; tx_data and tx_valid SHALL hold stable while tx_valid && !tx_ready.
REQ-022 tx_valid SHALL be 1 in HDR and DATA, 0 in IDLE and DONE; first tx_valid appears the cycle after accept (latency 1).
REQ-023 Byte counter SHALL be ceil(log2(DATA_BYTES+1)) bits, clear on accept, increment per payload transfer, DATA exits when count reaches DATA_BYTES-1 and transfers.
REQ-024 With tx_ready held 1, a write frame SHALL occupy DATA_BYTES+1 consecutive tx cycles, a read frame 1 cycle.
REQ-025 frame_done SHALL assert exactly in DONE; busy SHALL be 1 in HDR, DATA, DONE.
REQ-026 cmd_valid during busy SHALL be held off (cmd_ready = 0), never dropped or merged; next accept earliest the cycle after DONE.
REQ-027 tx_ready asserted while tx_valid = 0 SHALL have no effect.

Reset
REQ-028 rst SHALL force, asynchronously: state IDLE, counter 0, payload register 0, tx_data 8'h00, tx_valid 0, busy 0, frame_done 0, cmd_ready 0 while rst high, 1 first cycle after release.
REQ-029 Reset mid-frame SHALL abort the frame without emitting further bytes; no frame_done is generated for it.

Structure
REQ-030 HDR_WR, HDR_RD and state encodings SHALL live in the shared command-protocol package used by the decoder, so both ends match.
REQ-031 Single flat module; payload shift register and FSM in one block, no sub-module.

Verification
REQ-032 Write cmd_data=32'h1122_3344, tx_ready=1 -> tx bytes 55,11,22,33,44 on 5 consecutive cycles, frame_done one cycle later.
REQ-033 Read cmd_rd=1, tx_ready=1 -> single byte AA, then frame_done, cmd_ready back to 1 next cycle.
REQ-034 Write 32'hDEAD_BEEF with tx_ready toggling 1,0,0,1,... -> bytes 55,DE,AD,BE,EF, tx_data stable through every stall.
REQ-035 cmd_valid held high with alternating write/read commands -> frames back-to-back with exactly one IDLE cycle between, no lost command.
REQ-036 Assert rst after second payload byte -> tx_valid 0 immediately, no frame_done; next write after release emits full fresh frame starting 55.
REQ-037 Loopback through the UART transmitter/receiver into the command decoder -> decoder raises wr_trig with payload 11,22,33,44 and rd_trig for AA frame.

Source files
------------

// File: rtl/cmd_encode_pkg.sv
// Command-protocol constants shared by the command encoder and the UART command decoder.
// Frame headers and FSM state encodings live here so both ends of the link agree.
package cmd_encode_pkg;

    localparam logic [7:0] CMD_HDR_WR = 8'h55;
    localparam logic [7:0] CMD_HDR_RD = 8'hAA;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic [7:0] hdr_byte(input logic rd,
                                            input logic [7:0] hdr_wr,
                                            input logic [7:0] hdr_rd);
        return rd ? hdr_rd : hdr_wr;
    endfunction

endpackage

// File: rtl/cmd_encode.sv
// Serialises write/read commands into byte frames (header, then MSB-first payload for writes)
// for a ready/valid byte sink such as a UART transmitter.
module cmd_encode
    import cmd_encode_pkg::*;
#(
    parameter logic [7:0] HDR_WR     = CMD_HDR_WR,
    parameter logic [7:0] HDR_RD     = CMD_HDR_RD,
    parameter int         DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rd,
    input  logic [8*DATA_BYTES-1:0] cmd_data,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int PW    = 8 * DATA_BYTES;
    localparam int CNT_W = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    payload_reg;
    logic             rd_reg;
    logic [7:0]       tx_data_reg;

    // Ready is gated by rst so it reads 0 during reset and 1 as soon as reset releases.
    assign cmd_ready  = (state_reg == ST_IDLE) && !rst;
    assign tx_valid   = (state_reg == ST_HDR) || (state_reg == ST_DATA);
    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = (state_reg == ST_DONE);
    assign tx_data    = tx_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            payload_reg <= '0;
            rd_reg      <= 1'b0;
            tx_data_reg <= 8'h00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_reg   <= ST_HDR;
                        rd_reg      <= cmd_rd;
                        payload_reg <= cmd_data;
                        cnt_reg     <= '0;
                        tx_data_reg <= hdr_byte(cmd_rd, HDR_WR, HDR_RD);
                    end
                end
                ST_HDR: begin
                    if (tx_ready) begin
                        if (rd_reg) begin
                            state_reg   <= ST_DONE;
                            tx_data_reg <= 8'h00;
                        end else begin
                            // Preload the first payload byte and shift it out of the register.
                            state_reg   <= ST_DATA;
                            tx_data_reg <= payload_reg[PW-1 -: 8];
                            payload_reg <= payload_reg << 8;
                        end
                    end
                end
                ST_DATA: begin
                    if (tx_ready) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            state_reg   <= ST_DONE;
                            tx_data_reg <= 8'h00;
                        end else begin
                            tx_data_reg <= payload_reg[PW-1 -: 8];
                            payload_reg <= payload_reg << 8;
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_encode.sv
// Directed bench for cmd_encode: frame contents, stalls, back-to-back commands and mid-frame reset.
module tb_cmd_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [31:0] cmd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    cmd_encode #(.HDR_WR(8'h55), .HDR_RD(8'hAA), .DATA_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_data(cmd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b);
        chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, b});
        $display("byte %s: tx_data=%h tx_valid=%b", tag, tx_data, tx_valid);
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_nvalid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_nready"}, {31'd0, cmd_ready}, 32'd0);
        $display("frame_done %s", tag);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    endtask

    logic [7:0] bytes_q [5];
    logic [7:0] b;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        cmd_data  = 32'h0;
        tx_ready  = 1'b0;

        // Reset state
        step();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        expect_idle("post_rst");

        // tx_ready while idle does nothing
        tx_ready = 1'b1;
        step();
        expect_idle("idle_txr");
        chk("idle_txr_valid", {31'd0, tx_valid}, 32'd0);

        // Write 11223344, tx_ready held high
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = 32'h1122_3344;
        step();
        cmd_valid = 1'b0; cmd_data = 32'hFFFF_FFFF; cmd_rd = 1'b1;
        chk("wr1_busy", {31'd0, busy}, 32'd1);
        bytes_q = '{8'h55, 8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 5; i++) begin
            expect_byte($sformatf("wr1_b%0d", i), bytes_q[i]);
            step();
        end
        expect_done("wr1");
        step();
        expect_idle("wr1_end");

        // Read command
        cmd_valid = 1'b1; cmd_rd = 1'b1;
        step();
        cmd_valid = 1'b0; cmd_rd = 1'b0;
        expect_byte("rd1_hdr", 8'hAA);
        step();
        expect_done("rd1");
        step();
        expect_idle("rd1_end");

        // Write DEADBEEF with stalls: each byte held for two stalled cycles
        tx_ready = 1'b0;
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = 32'hDEAD_BEEF;
        step();
        cmd_valid = 1'b0; cmd_data = 32'h0;
        bytes_q = '{8'h55, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 5; i++) begin
            expect_byte($sformatf("stall_b%0d", i), bytes_q[i]);
            tx_ready = 1'b0;
            step();
            expect_byte($sformatf("stall_b%0d_s1", i), bytes_q[i]);
            step();
            expect_byte($sformatf("stall_b%0d_s2", i), bytes_q[i]);
            tx_ready = 1'b1;
            step();
        end
        expect_done("stall");
        step();
        expect_idle("stall_end");

        // Back-to-back: write, read, write with cmd_valid held high
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = 32'hA1B2_C3D4;
        step();
        cmd_rd = 1'b1; cmd_data = 32'h0102_0304;
        bytes_q = '{8'h55, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 5; i++) begin
            expect_byte($sformatf("b2b_w_b%0d", i), bytes_q[i]);
            chk($sformatf("b2b_w_hold%0d", i), {31'd0, cmd_ready}, 32'd0);
            step();
        end
        expect_done("b2b_w");
        step();
        expect_idle("b2b_gap1");
        step();
        cmd_rd = 1'b0;
        expect_byte("b2b_r_hdr", 8'hAA);
        step();
        expect_done("b2b_r");
        step();
        expect_idle("b2b_gap2");
        step();
        cmd_valid = 1'b0;
        bytes_q = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 5; i++) begin
            expect_byte($sformatf("b2b_w2_b%0d", i), bytes_q[i]);
            step();
        end
        expect_done("b2b_w2");
        step();
        expect_idle("b2b_end");

        // Reset after second payload byte transfers
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = 32'h1122_3344;
        step();
        cmd_valid = 1'b0;
        expect_byte("abort_b0", 8'h55);
        step();
        expect_byte("abort_b1", 8'h11);
        step();
        expect_byte("abort_b2", 8'h22);
        step();
        expect_byte("abort_b3", 8'h33);
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        chk("abort_data", {24'd0, tx_data}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("abort_nofd%0d", i), {31'd0, frame_done}, 32'd0);
            chk($sformatf("abort_novalid%0d", i), {31'd0, tx_valid}, 32'd0);
        end
        rst = 1'b0;
        #1;
        expect_idle("abort_rel");
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_data = 32'h5566_7788;
        step();
        cmd_valid = 1'b0;
        bytes_q = '{8'h55, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 5; i++) begin
            b = bytes_q[i];
            expect_byte($sformatf("fresh_b%0d", i), b);
            step();
        end
        expect_done("fresh");
        step();
        expect_idle("fresh_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
